mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4, memory address width.
REQ-002 Parameter DATA_W, default 4, memory data width.
REQ-003 clka  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req0 / req1  input  1  request from requester 0 / 1; held high until matching ack.
REQ-006 we0 / we1  input  1  1 = write, 0 = read; stable while req high.
REQ-007 addr0 / addr1  input  ADDR_W  target address; stable while req high.
REQ-008 wdata0 / wdata1  input  DATA_W  write data; stable while req high.
REQ-009 ack0 / ack1  output  1  one-cycle completion pulse, registered.
REQ-010 rdata0 / rdata1  output  DATA_W  read data, valid in the ack cycle, held until that requester's next read completes.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 mem_ena  output  1  memory enable to the single-port block memory.
REQ-013 mem_wea  output  1  memory write enable.
REQ-014 mem_addra  output  ADDR_W  memory address.
REQ-015 mem_dina  output  DATA_W  memory write data.
REQ-016 mem_douta  input  DATA_W  memory read data, one-cycle synchronous read latency.

Function
REQ-017 FSM states: IDLE, ACCESS, RDWAIT, DONE.
REQ-018 IDLE: with neither req high, remain in IDLE; otherwise grant one requester, latch its we/addr/wdata and its index, go to ACCESS.
REQ-019 Arbitration is round-robin: rr_ptr names the preferred requester; if both reqs are high, grant rr_ptr; if only one is high, grant that one.
REQ-020 rr_ptr switches to the non-granted requester on every grant.
REQ-021 ACCESS: mem_ena=1, mem_addra=latched addr, mem_dina=latched wdata, mem_wea=latched we; next state DONE if write, else RDWAIT.
REQ-022 Outside ACCESS: mem_ena=0, mem_wea=0; mem_addra and mem_dina hold their last values.
REQ-023 RDWAIT: capture mem_douta into the granted requester's rdata register on the closing edge; next state DONE.
REQ-024 DONE: assert the granted requester's ack for exactly one cycle; next state IDLE.
REQ-025 Latency from req sampled in IDLE to ack: write, 2 cycles; read, 3 cycles.
REQ-026 req is sampled only in IDLE; changes to req or its fields in other states are ignored.
REQ-027 A req still high in the IDLE cycle after ack counts as a new request (back-to-back allowed).
REQ-028 At most one ack is high in any cycle; ack is never high outside DONE.
REQ-029 The non-granted requester's rdata is never modified.

Reset
REQ-030 While rst is high, the block asynchronously forces: state=IDLE, rr_ptr=0, ack0=ack1=0, busy=0, mem_ena=0, mem_wea=0, mem_addra=0, mem_dina=0, rdata0=rdata1=0, latched fields=0.
REQ-031 Reset asserted mid-transaction aborts it: no ack is issued and no write is issued after reset asserts.
REQ-032 After rst deasserts, the first rising edge evaluates IDLE normally.

Structure
REQ-033 Shared package mem_arbiter_pkg holds the state enum type and the ADDR_W and DATA_W default constants.
REQ-034 One sub-module rr_pick (2-input round-robin select: req0, req1, rr_ptr -> grant valid, grant index) is used; all else is in mem_arbiter.
REQ-035 The memory is external; the bench models it as 16x4 with a registered 1-cycle read.

Verification
REQ-036 Reset, then req0 write addr=3, wdata=0xA -> mem_wea high for 1 cycle with addra=3, dina=0xA; ack0 pulses 2 cycles after sampling.
REQ-037 After REQ-036, req1 read addr=3 -> ack1 3 cycles after sampling, rdata1=0xA, rdata0 unchanged.
REQ-038 req0 and req1 both held high continuously, rr_ptr=0 after reset -> grants alternate 0,1,0,1; no ack overlap; 4 acks each within 4 grants apiece.
REQ-039 Only req1 high while rr_ptr=0 -> req1 granted with no idle cycles lost.
REQ-040 rst asserted during RDWAIT of a read by requester 0 -> no ack0, rdata0=0, busy=0 immediately, next req served normally.
REQ-041 Write addr=15 wdata=0xF, then read addr=15 -> rdata=0xF (address boundary).

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM state type
// and the default address/data widths.
package mem_arbiter_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Two-input round-robin select. When both requests are present the preferred
// requester (rr_ptr) wins; a lone request is granted regardless of rr_ptr.
module rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic rr_ptr,
    output logic grant_valid,
    output logic grant_idx
);

    // Combinational grant decision
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
        grant_valid = req0 | req1;
        grant_idx   = (req0 & req1) ? rr_ptr : req1;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving two requesters access to one single-port
// synchronous block memory. One transaction at a time:
//   IDLE -> ACCESS -> DONE            (write, ack two cycles after sampling)
//   IDLE -> ACCESS -> RDWAIT -> DONE  (read,  ack three cycles after sampling)
// The memory-port address/data registers double as the latched request fields.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              mem_ena,
    output logic              mem_wea,
    output logic [ADDR_W-1:0] mem_addra,
    output logic [DATA_W-1:0] mem_dina,
    input  logic [DATA_W-1:0] mem_douta
);

    state_t            state;
    logic              rr_ptr;
    logic              lat_we;
    logic              lat_idx;
    logic              grant_valid;
    logic              grant_idx;
    logic              take;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_pick u_rr_pick (
        .req0        (req0),
        .req1        (req1),
        .rr_ptr      (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Requests are only looked at in IDLE; pick the granted requester's fields
    always_comb begin
        take      = (state == IDLE) && grant_valid;
        sel_we    = grant_idx ? we1    : we0;
        sel_addr  = grant_idx ? addr1  : addr0;
        sel_wdata = grant_idx ? wdata1 : wdata0;
    end

    assign busy = (state != IDLE);

    // Transaction sequencing, round-robin pointer and the registered ack pulse
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= 1'b0;
            lat_we  <= 1'b0;
            lat_idx <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        state   <= ACCESS;
                        lat_we  <= sel_we;
                        lat_idx <= grant_idx;
                        rr_ptr  <= ~grant_idx;
                    end
                end
                ACCESS: begin
                    if (lat_we) begin
                        state <= DONE;
                        ack0  <= ~lat_idx;
                        ack1  <= lat_idx;
                    end else begin
                        state <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    state <= DONE;
                    ack0  <= ~lat_idx;
                    ack1  <= lat_idx;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory port: enable/write only during ACCESS, address/data held otherwise
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            mem_ena   <= 1'b0;
            mem_wea   <= 1'b0;
            mem_addra <= '0;
            mem_dina  <= '0;
        end else begin
            mem_ena <= take;
            mem_wea <= take & sel_we;
            if (take) begin
                mem_addra <= sel_addr;
                mem_dina  <= sel_wdata;
            end
        end
    end

    // Capture read data into the granted requester's register only
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else if (state == RDWAIT) begin
            if (lat_idx) rdata1 <= mem_douta;
            else         rdata0 <= mem_douta;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// multi-cycle sequences (contention, reset mid-read) and randomized single
// transactions checked against a transaction-level reference model.
module tb_mem_arbiter;

    logic       clka;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [3:0] addr0, addr1, wdata0, wdata1;
    logic       ack0, ack1, busy;
    logic [3:0] rdata0, rdata1;
    logic       mem_ena, mem_wea;
    logic [3:0] mem_addra, mem_dina, mem_douta;

    int n_tests = 0;
    int n_fail  = 0;
    int viol    = 0;

    mem_arbiter dut (
        .clka      (clka),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .busy      (busy),
        .mem_ena   (mem_ena),
        .mem_wea   (mem_wea),
        .mem_addra (mem_addra),
        .mem_dina  (mem_dina),
        .mem_douta (mem_douta)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    // External 16x4 block memory, registered read (read-first)
    logic [3:0] mem [16];
    initial for (int i = 0; i < 16; i++) mem[i] = 4'h0;
    initial mem_douta = 4'h0;
    always @(posedge clka) begin
        if (mem_ena) begin
            if (mem_wea) mem[mem_addra] <= mem_dina;
            mem_douta <= mem[mem_addra];
        end
    end

    // Protocol watch: never two acks, never an ack while idle, no write without enable
    always @(negedge clka) begin
        if (ack0 && ack1) viol++;
        if ((ack0 || ack1) && !busy) viol++;
        if (mem_wea && !mem_ena) viol++;
    end

    // Reference model: memory contents and each requester's visible read data
    logic [3:0] ref_mem [16];
    logic [3:0] exp_rd  [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_apply(input bit idx, input logic w, input logic [3:0] a, input logic [3:0] d);
        if (w) ref_mem[a] = d;
        else   exp_rd[idx] = ref_mem[a];
    endtask

    task automatic apply_reset();
        @(negedge clka);
        rst = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge clka);
        rst = 1'b0;
        exp_rd[0] = 4'h0;
        exp_rd[1] = 4'h0;
    endtask

    // One transaction from an idle arbiter; reports latency, read data and write activity
    task automatic do_txn(input bit idx, input logic w, input logic [3:0] a, input logic [3:0] d,
                          output int lat, output logic [3:0] rd, output logic [3:0] rd_other,
                          output int wcnt, output logic [3:0] waddr, output logic [3:0] wdat);
        int guard;
        guard = 0;
        while (busy && guard < 20) begin
            @(negedge clka);
            guard++;
        end
        if (idx) begin we1 = w; addr1 = a; wdata1 = d; req1 = 1'b1; end
        else     begin we0 = w; addr0 = a; wdata0 = d; req0 = 1'b1; end
        lat = 0; wcnt = 0; waddr = 4'h0; wdat = 4'h0;
        forever begin
            @(posedge clka);
            lat++;
            @(negedge clka);
            if (mem_wea) begin wcnt++; waddr = mem_addra; wdat = mem_dina; end
            if ((idx ? ack1 : ack0) || lat >= 16) break;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        rd       = idx ? rdata1 : rdata0;
        rd_other = idx ? rdata0 : rdata1;
    endtask

    // Run one transaction and compare against the supplied expectations
    task automatic run_check(input string tag, input bit idx, input logic w, input logic [3:0] a,
                             input logic [3:0] d, input int exp_lat,
                             input logic [3:0] exp_own, input logic [3:0] exp_oth);
        int lat, wcnt;
        logic [3:0] rd, rdo, wa, wd;
        do_txn(idx, w, a, d, lat, rd, rdo, wcnt, wa, wd);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_rdata_own"}, rd, exp_own);
        check({tag, "_rdata_other"}, rdo, exp_oth);
        check({tag, "_write_pulses"}, wcnt, w ? 1 : 0);
        if (w) begin
            check({tag, "_write_addr"}, wa, a);
            check({tag, "_write_data"}, wd, d);
        end
    endtask

    typedef struct {
        bit         idx;
        logic       we;
        logic [3:0] addr;
        logic [3:0] wdata;
        int         exp_lat;
        logic [3:0] exp_own;
        logic [3:0] exp_oth;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int ack_cnt, cyc;
        int ack_idx [$];
        int ack_cyc [$];
        int stray;

        vecs[0] = '{1'b0, 1'b1, 4'd3,  4'hA, 2, 4'h0, 4'h0};
        vecs[1] = '{1'b1, 1'b0, 4'd3,  4'h0, 3, 4'hA, 4'h0};
        vecs[2] = '{1'b0, 1'b1, 4'd15, 4'hF, 2, 4'h0, 4'hA};
        vecs[3] = '{1'b1, 1'b0, 4'd15, 4'h0, 3, 4'hF, 4'h0};
        vecs[4] = '{1'b0, 1'b0, 4'd3,  4'h0, 3, 4'hA, 4'hF};
        vecs[5] = '{1'b1, 1'b1, 4'd0,  4'h5, 2, 4'hF, 4'hA};
        vecs[6] = '{1'b0, 1'b0, 4'd0,  4'h0, 3, 4'h5, 4'hF};

        for (int i = 0; i < 16; i++) ref_mem[i] = 4'h0;
        exp_rd[0] = 4'h0;
        exp_rd[1] = 4'h0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;

        // Reset state
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("reset_busy", busy, 0);
        check("reset_acks", {ack0, ack1}, 0);
        check("reset_mem_ctl", {mem_ena, mem_wea}, 0);
        check("reset_mem_addr_data", {mem_addra, mem_dina}, 0);
        check("reset_rdata", {rdata0, rdata1}, 0);
        repeat (2) @(negedge clka);
        rst = 1'b0;

        // Directed vectors, including the address-15 boundary
        for (int i = 0; i < 7; i++) begin
            run_check($sformatf("vec%0d", i), vecs[i].idx, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                      vecs[i].exp_lat, vecs[i].exp_own, vecs[i].exp_oth);
            model_apply(vecs[i].idx, vecs[i].we, vecs[i].addr, vecs[i].wdata);
        end

        // Contention: both held high from reset, grants must alternate 0,1,0,1,...
        apply_reset();
        we0 = 1'b0; addr0 = 4'd15;
        we1 = 1'b0; addr1 = 4'd3;
        req0 = 1'b1; req1 = 1'b1;
        ack_cnt = 0;
        for (cyc = 1; cyc <= 64 && ack_cnt < 8; cyc++) begin
            @(negedge clka);
            if (ack0) begin
                ack_idx.push_back(0); ack_cyc.push_back(cyc); ack_cnt++;
                check("rr_rdata0", rdata0, ref_mem[15]);
            end
            if (ack1) begin
                ack_idx.push_back(1); ack_cyc.push_back(cyc); ack_cnt++;
                check("rr_rdata1", rdata1, ref_mem[3]);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        exp_rd[0] = ref_mem[15];
        exp_rd[1] = ref_mem[3];
        check("rr_ack_count", ack_cnt, 8);
        for (int k = 0; k < ack_idx.size(); k++) begin
            check($sformatf("rr_order%0d", k), ack_idx[k], k % 2);
            if (k > 0) check($sformatf("rr_gap%0d", k), ack_cyc[k] - ack_cyc[k-1], 4);
            else       check("rr_first_ack", ack_cyc[k], 3);
        end

        // Reset during RDWAIT of a requester-0 read aborts it
        @(negedge clka);
        @(negedge clka);
        we0 = 1'b0; addr0 = 4'd3; req0 = 1'b1;
        @(posedge clka);
        @(posedge clka);
        @(negedge clka);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_ack0", ack0, 0);
        check("abort_rdata0", rdata0, 0);
        check("abort_mem_ctl", {mem_ena, mem_wea}, 0);
        req0 = 1'b0;
        exp_rd[0] = 4'h0;
        exp_rd[1] = 4'h0;
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clka);
            if (c == 1) rst = 1'b0;
            if (ack0 || ack1 || mem_wea) stray++;
        end
        check("abort_no_ack_or_write", stray, 0);

        // Only requester 1 while rr_ptr is 0 after reset: served without delay
        run_check("solo_req1", 1'b1, 1'b1, 4'd7, 4'h3, 2, 4'h0, 4'h0);
        model_apply(1'b1, 1'b1, 4'd7, 4'h3);
        run_check("post_abort_rd", 1'b0, 1'b0, 4'd15, 4'h0, 3, ref_mem[15], 4'h0);
        model_apply(1'b0, 1'b0, 4'd15, 4'h0);

        // Randomized single transactions against the reference model
        for (int n = 0; n < 40; n++) begin
            bit         ridx;
            logic       rw;
            logic [3:0] ra, rdv;
            int         elat;
            ridx = 1'($urandom_range(0, 1));
            rw   = 1'($urandom_range(0, 1));
            ra   = 4'($urandom_range(0, 15));
            rdv  = 4'($urandom_range(0, 15));
            elat = rw ? 2 : 3;
            model_apply(ridx, rw, ra, rdv);
            run_check($sformatf("rand%0d", n), ridx, rw, ra, rdv, elat, exp_rd[ridx], exp_rd[!ridx]);
        end

        check("protocol_violations", viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
